// File: rtl/calc_ctrl_if.sv
// Stack-side bus of the RPN calculator command sequencer.
// The sequencer (master) reads the stack status and tops and drives the
// one-cycle write transaction; the stack memory block is the slave.
interface calc_ctrl_if #(
  parameter int W = 32
);
  logic [9:0]   st_elems_cnt;
  logic [W-1:0] st_top0;
  logic [W-1:0] st_top1;
  logic         st_ready;
  logic         st_en;
  logic [1:0]   st_write_elems_cnt;
  logic [W-1:0] st_write_elem0;
  logic [W-1:0] st_write_elem1;
  logic [1:0]   st_top_mov;

  modport master (
    input  st_elems_cnt, st_top0, st_top1, st_ready,
    output st_en, st_write_elems_cnt, st_write_elem0, st_write_elem1, st_top_mov
  );

  modport slave (
    output st_elems_cnt, st_top0, st_top1, st_ready,
    input  st_en, st_write_elems_cnt, st_write_elem0, st_write_elem1, st_top_mov
  );
endinterface

// File: rtl/calc_ctrl.sv
// Command sequencer of the RPN stack calculator.
// Turns button presses into single stack transactions, validates operand
// counts, capacity and divide-by-zero up front, and runs a restoring divider
// for DIV/MOD before handing the result to the stack.
module calc_ctrl #(
  parameter int DEPTH = 512,
  parameter int W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [7:0]  sw,
  calc_ctrl_if.master st,
  output logic        err_flag,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {MOV_NO = 2'd0, MOV_UP = 2'd1, MOV_DN = 2'd2} mov_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_POP, OP_DUP, OP_SWAP
  } op_t;

  localparam int            CW        = $clog2(W);
  localparam logic [9:0]    DEPTH_CNT = 10'(DEPTH);
  localparam logic [CW-1:0] DIV_LAST  = CW'(W - 1);

  // Registered state
  state_t        r_state;
  logic [3:0]    r_btn_prev;
  logic          r_err;
  logic [1:0]    r_wcnt;
  logic [W-1:0]  r_elem0;
  logic [W-1:0]  r_elem1;
  mov_t          r_mov;
  logic [W-1:0]  r_quo;       // dividend shifts out, quotient shifts in
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dvsr;
  logic          r_div_mod;   // 1: deliver remainder, 0: deliver quotient
  logic [CW-1:0] r_div_cnt;
  logic          r_wait_first;

  // Next-state values
  state_t        w_state_nxt;
  logic          w_err_nxt;
  logic [1:0]    w_wcnt_nxt;
  logic [W-1:0]  w_elem0_nxt;
  logic [W-1:0]  w_elem1_nxt;
  mov_t          w_mov_nxt;
  logic [W-1:0]  w_quo_nxt;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_dvsr_nxt;
  logic          w_div_mod_nxt;
  logic [CW-1:0] w_div_cnt_nxt;
  logic          w_wait_first_nxt;
  logic          w_st_en;

  // Decoded command
  logic [3:0]    w_press;
  logic          w_unused;
  op_t           w_op;
  logic          w_room;
  logic          w_ge1;
  logic          w_ge2;
  logic          w_acc;
  logic          w_rej;
  logic          w_div;
  mov_t          w_cmd_mov;
  logic [1:0]    w_cmd_wcnt;
  logic [W-1:0]  w_cmd_e0;
  logic [W-1:0]  w_cmd_e1;

  // Divider step
  logic [W:0]    w_rem_sh;
  logic [W:0]    w_rem_sub;
  logic [W-1:0]  w_rem_step;
  logic [W-1:0]  w_quo_step;

  assign w_press  = btn & ~r_btn_prev;
  assign w_unused = w_press[0];        // btn[0] only drives the display
  assign w_op     = op_t'(sw[2:0]);
  assign w_room   = st.st_elems_cnt < DEPTH_CNT;
  assign w_ge1    = st.st_elems_cnt >= 10'd1;
  assign w_ge2    = st.st_elems_cnt >= 10'd2;

  // Resolve the highest-priority press into one validated command.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_acc      = 1'b0;
    w_rej      = 1'b0;
    w_div      = 1'b0;
    w_cmd_mov  = MOV_NO;
    w_cmd_wcnt = 2'd0;
    w_cmd_e0   = '0;
    w_cmd_e1   = '0;
    if (w_press[1]) begin
      if (w_room) begin
        w_acc      = 1'b1;
        w_cmd_mov  = MOV_UP;
        w_cmd_wcnt = 2'd1;
        w_cmd_e0   = {{(W-8){1'b0}}, sw};
      end else begin
        w_rej = 1'b1;
      end
    end else if (w_press[2]) begin
      if (w_ge1) begin
        w_acc      = 1'b1;
        w_cmd_wcnt = 2'd1;
        w_cmd_e0   = {st.st_top0[W-9:0], sw};
      end else begin
        w_rej = 1'b1;
      end
    end else if (w_press[3]) begin
      unique case (w_op)
        OP_ADD, OP_SUB, OP_MUL: begin
          if (w_ge2) begin
            w_acc      = 1'b1;
            w_cmd_mov  = MOV_DN;
            w_cmd_wcnt = 2'd1;
            if (w_op == OP_ADD)      w_cmd_e0 = st.st_top1 + st.st_top0;
            else if (w_op == OP_SUB) w_cmd_e0 = st.st_top1 - st.st_top0;
            else                     w_cmd_e0 = st.st_top1 * st.st_top0;
          end else begin
            w_rej = 1'b1;
          end
        end
        OP_DIV, OP_MOD: begin
          // A zero divisor is caught here so the divider never starts on it.
          if (w_ge2 && (st.st_top0 != '0)) w_div = 1'b1;
          else                             w_rej = 1'b1;
        end
        OP_POP: begin
          if (w_ge1) begin
            w_acc     = 1'b1;
            w_cmd_mov = MOV_DN;
          end else begin
            w_rej = 1'b1;
          end
        end
        OP_DUP: begin
          if (w_ge1 && w_room) begin
            w_acc      = 1'b1;
            w_cmd_mov  = MOV_UP;
            w_cmd_wcnt = 2'd1;
            w_cmd_e0   = st.st_top0;
          end else begin
            w_rej = 1'b1;
          end
        end
        OP_SWAP: begin
          if (w_ge2) begin
            w_acc      = 1'b1;
            w_cmd_wcnt = 2'd2;
            w_cmd_e0   = st.st_top1;
            w_cmd_e1   = st.st_top0;
          end else begin
            w_rej = 1'b1;
          end
        end
      endcase
    end
  end

  // One restoring-division step: shift in the next dividend bit, try to subtract.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[W-1]};
    w_rem_sub = w_rem_sh - {1'b0, r_dvsr};
    if (!w_rem_sub[W]) begin
      w_rem_step = w_rem_sub[W-1:0];
      w_quo_step = {r_quo[W-2:0], 1'b1};
    end else begin
      w_rem_step = w_rem_sh[W-1:0];
      w_quo_step = {r_quo[W-2:0], 1'b0};
    end
  end

  // Next-state and output decisions of the command FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_err_nxt        = r_err;
    w_wcnt_nxt       = r_wcnt;
    w_elem0_nxt      = r_elem0;
    w_elem1_nxt      = r_elem1;
    w_mov_nxt        = r_mov;
    w_quo_nxt        = r_quo;
    w_rem_nxt        = r_rem;
    w_dvsr_nxt       = r_dvsr;
    w_div_mod_nxt    = r_div_mod;
    w_div_cnt_nxt    = r_div_cnt;
    w_wait_first_nxt = 1'b0;
    w_st_en          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_nxt = S_ISSUE;
          w_err_nxt   = 1'b0;
          w_mov_nxt   = w_cmd_mov;
          w_wcnt_nxt  = w_cmd_wcnt;
          w_elem0_nxt = w_cmd_e0;
          w_elem1_nxt = w_cmd_e1;
        end else if (w_div) begin
          w_state_nxt   = S_DIV;
          w_err_nxt     = 1'b0;
          w_mov_nxt     = MOV_DN;
          w_wcnt_nxt    = 2'd1;
          w_elem1_nxt   = '0;
          w_quo_nxt     = st.st_top1;
          w_rem_nxt     = '0;
          w_dvsr_nxt    = st.st_top0;
          w_div_mod_nxt = (w_op == OP_MOD);
          w_div_cnt_nxt = DIV_LAST;
        end else if (w_rej) begin
          w_err_nxt = 1'b1;
        end
      end
      S_DIV: begin
        w_quo_nxt     = w_quo_step;
        w_rem_nxt     = w_rem_step;
        w_div_cnt_nxt = r_div_cnt - CW'(1);
        if (r_div_cnt == '0) begin
          w_elem0_nxt = r_div_mod ? w_rem_step : w_quo_step;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (st.st_ready) begin
          w_st_en          = 1'b1;
          w_wait_first_nxt = 1'b1;
          w_state_nxt      = S_WAIT;
        end
      end
      S_WAIT: begin
        // The stack may still show ready in the cycle right after en.
        if (!r_wait_first && st.st_ready) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath, output and edge-detect registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      r_btn_prev   <= 4'b1111;   // a button held through reset must not fire
      r_err        <= 1'b0;
      r_wcnt       <= 2'd0;
      r_elem0      <= '0;
      r_elem1      <= '0;
      r_mov        <= MOV_NO;
      r_quo        <= '0;
      r_rem        <= '0;
      r_dvsr       <= '0;
      r_div_mod    <= 1'b0;
      r_div_cnt    <= '0;
      r_wait_first <= 1'b0;
    end else begin
      r_btn_prev   <= btn;
      r_err        <= w_err_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_elem0      <= w_elem0_nxt;
      r_elem1      <= w_elem1_nxt;
      r_mov        <= w_mov_nxt;
      r_quo        <= w_quo_nxt;
      r_rem        <= w_rem_nxt;
      r_dvsr       <= w_dvsr_nxt;
      r_div_mod    <= w_div_mod_nxt;
      r_div_cnt    <= w_div_cnt_nxt;
      r_wait_first <= w_wait_first_nxt;
    end
  end

  // The strobe is gated by reset so an aborted command never reaches the stack.
  assign st.st_en              = w_st_en & rst_n;
  assign st.st_write_elems_cnt = r_wcnt;
  assign st.st_write_elem0     = r_elem0;
  assign st.st_write_elem1     = r_elem1;
  assign st.st_top_mov         = r_mov;
  assign err_flag              = r_err;
  assign busy                  = (r_state != S_IDLE);

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl. A behavioural stack model feeds the DUT and
// predicts every transaction from the command rules; one compare process
// checks each st_en, the strobe width and err_flag on every cycle.
module tb_calc_ctrl;
  localparam int W     = 32;
  localparam int DEPTH = 512;

  typedef struct {
    logic [1:0]   mov;
    logic [1:0]   wcnt;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    int           cyc;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [7:0] sw = 8'h0;
  logic       err_flag;
  logic       busy;

  calc_ctrl_if #(.W(W)) bus ();

  calc_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .sw       (sw),
    .st       (bus),
    .err_flag (err_flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Model state
  logic [W-1:0] m_mem [DEPTH];
  int           m_cnt = 0;
  logic         m_err = 1'b0;
  logic         tb_ready = 1'b1;
  logic         force_low = 1'b0;
  logic         en_last = 1'b0;
  logic         en_prev = 1'b0;
  int           cyc = 0;
  txn_t         exp_q[$];
  txn_t         cmp_e;
  int           n_vec = 0;
  int           n_bad = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  end

  always_comb begin
    bus.st_elems_cnt = 10'(m_cnt);
    bus.st_top0      = (m_cnt >= 1) ? m_mem[m_cnt-1] : '0;
    bus.st_top1      = (m_cnt >= 2) ? m_mem[m_cnt-2] : '0;
    bus.st_ready     = tb_ready;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stack ready: drops for the cycle after each en, or while forced low.
  always begin
    @(posedge clk);
    #2;
    tb_ready = !force_low && !en_last;
    en_last  = 1'b0;
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic apply(input txn_t e);
    if (e.mov == 2'd1)      m_cnt++;
    else if (e.mov == 2'd2) m_cnt--;
    if (e.wcnt >= 2'd1) m_mem[m_cnt-1] = e.e0;
    if (e.wcnt == 2'd2) m_mem[m_cnt-2] = e.e1;
  endtask

  // Compare process.
  always @(negedge clk) begin
    check("en_single_cycle", {31'b0, bus.st_en & en_prev}, 0);
    if (bus.st_en) begin
      check("en_expected", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        cmp_e = exp_q.pop_front();
        check("top_mov", bus.st_top_mov, cmp_e.mov);
        check("wcnt", bus.st_write_elems_cnt, cmp_e.wcnt);
        if (cmp_e.wcnt != 2'd0) check("elem0", bus.st_write_elem0, cmp_e.e0);
        if (cmp_e.wcnt == 2'd2) check("elem1", bus.st_write_elem1, cmp_e.e1);
        if (cmp_e.cyc >= 0)     check("latency", cyc, cmp_e.cyc);
        apply(cmp_e);
      end
      en_last = 1'b1;
    end
    en_prev = bus.st_en;
    check("err_flag", {31'b0, err_flag}, {31'b0, m_err});
  end

  // Predict the command from the model, drive the press, return the expectation.
  // kind: 0 no press, 1 accepted, 2 rejected.
  task automatic fire(input logic [3:0] b, input logic [7:0] s, input int rl,
                      input int hold, output txn_t e, output int kind);
    logic [W-1:0] a;
    logic [W-1:0] t0;
    bit           isdiv;
    t0 = (m_cnt >= 1) ? m_mem[m_cnt-1] : '0;
    a  = (m_cnt >= 2) ? m_mem[m_cnt-2] : '0;
    e.mov = 2'd0; e.wcnt = 2'd0; e.e0 = '0; e.e1 = '0;
    kind = 0; isdiv = 0;
    if (b[1]) begin
      if (m_cnt < DEPTH) begin kind = 1; e.mov = 2'd1; e.wcnt = 2'd1; e.e0 = W'(s); end
      else kind = 2;
    end else if (b[2]) begin
      if (m_cnt >= 1) begin kind = 1; e.wcnt = 2'd1; e.e0 = (t0 << 8) | W'(s); end
      else kind = 2;
    end else if (b[3]) begin
      case (s[2:0])
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
          if (m_cnt < 2 || (s[2:0] >= 3'd3 && t0 == 0)) kind = 2;
          else begin
            kind = 1; e.mov = 2'd2; e.wcnt = 2'd1;
            case (s[2:0])
              3'd0:    e.e0 = a + t0;
              3'd1:    e.e0 = a - t0;
              3'd2:    e.e0 = a * t0;
              3'd3:    begin e.e0 = a / t0; isdiv = 1; end
              default: begin e.e0 = a % t0; isdiv = 1; end
            endcase
          end
        end
        3'd5: if (m_cnt >= 1) begin kind = 1; e.mov = 2'd2; end else kind = 2;
        3'd6: if (m_cnt >= 1 && m_cnt < DEPTH) begin
                kind = 1; e.mov = 2'd1; e.wcnt = 2'd1; e.e0 = t0;
              end else kind = 2;
        default: if (m_cnt >= 2) begin
                   kind = 1; e.wcnt = 2'd2; e.e0 = a; e.e1 = t0;
                 end else kind = 2;
      endcase
    end
    e.cyc = cyc + 1 + rl + (isdiv ? W : 0);
    if (kind == 1) exp_q.push_back(e);
    if (rl > 0) force_low = 1'b1;
    btn = b;
    sw  = s;
    @(posedge clk); #1;
    if (kind == 1)      m_err = 1'b0;
    else if (kind == 2) m_err = 1'b1;
    if (hold > 1) repeat (hold - 1) begin @(posedge clk); #1; end
    btn = 4'b0;
    if (rl > 0) begin
      repeat (rl) begin @(posedge clk); #1; end
      force_low = 1'b0;
    end
  endtask

  task automatic settle(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || busy) && n < 300);
    check({name, "_done"}, {31'b0, exp_q.size() == 0 && !busy}, 1);
    @(posedge clk); #1;
  endtask

  task automatic expect_reject(input string name);
    repeat (4) begin
      @(negedge clk);
      check({name, "_busy"}, {31'b0, busy}, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_en"},    {31'b0, bus.st_en}, 0);
    check({name, "_wcnt"},  bus.st_write_elems_cnt, 0);
    check({name, "_elem0"}, bus.st_write_elem0, 0);
    check({name, "_elem1"}, bus.st_write_elem1, 0);
    check({name, "_mov"},   bus.st_top_mov, 0);
    check({name, "_err"},   {31'b0, err_flag}, 0);
    check({name, "_busy"},  {31'b0, busy}, 0);
  endtask

  task automatic load2(input logic [W-1:0] a, input logic [W-1:0] b);
    m_mem[0] = a;
    m_mem[1] = b;
    m_cnt    = 2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t e;
    int   k;
    int   t;

    // Reset
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // PUSH 5, PUSH 3, SUB -> 2
    fire(4'b0010, 8'h05, 0, 1, e, k); settle("push5");
    fire(4'b0010, 8'h03, 0, 1, e, k); settle("push3");
    fire(4'b1000, 8'h01, 0, 1, e, k);
    check("pin_sub", e.e0, 2);
    settle("sub");
    check("pin_sub_cnt", m_cnt, 1);

    // DIV and MOD through the divider
    load2(100, 7);
    fire(4'b1000, 8'h03, 0, 1, e, k);
    check("pin_div", e.e0, 14);
    settle("div");
    check("pin_div_top", m_mem[0], 14);
    load2(100, 7);
    fire(4'b1000, 8'h04, 0, 1, e, k);
    check("pin_mod", e.e0, 2);
    settle("mod");
    load2(32'hF000_0001, 3);
    fire(4'b1000, 8'h03, 0, 1, e, k); check("pin_div_big", e.e0, 32'h5000_0000); settle("div_big");
    load2(32'hF000_0001, 3);
    fire(4'b1000, 8'h04, 0, 1, e, k); settle("mod_big");
    load2(7, 100);
    fire(4'b1000, 8'h04, 0, 1, e, k); check("pin_mod_small", e.e0, 7); settle("mod_small");

    // Too few operands, then recovery
    m_cnt = 1;
    fire(4'b1000, 8'h00, 0, 1, e, k);
    check("pin_add_rej", k, 2);
    expect_reject("add_cnt1");
    fire(4'b0010, 8'h22, 0, 1, e, k); settle("push_after_err");

    // Divide by zero
    load2(9, 0);
    fire(4'b1000, 8'h03, 0, 1, e, k); expect_reject("div_zero");
    fire(4'b1000, 8'h04, 0, 1, e, k); expect_reject("mod_zero");

    // Capacity
    m_cnt = DEPTH;
    fire(4'b0010, 8'h11, 0, 1, e, k); expect_reject("push_full");
    fire(4'b1000, 8'h06, 0, 1, e, k); expect_reject("dup_full");
    m_cnt = DEPTH - 1;
    fire(4'b0010, 8'h11, 0, 1, e, k); settle("push_last");
    check("pin_full_cnt", m_cnt, DEPTH);
    m_cnt = DEPTH - 1;
    fire(4'b1000, 8'h06, 0, 1, e, k); settle("dup_last");

    // Other operations
    load2(32'h0001_0000, 32'h0001_0001);
    fire(4'b1000, 8'h02, 0, 1, e, k); check("pin_mul", e.e0, 32'h0001_0000); settle("mul");
    load2(32'hFFFF_FFFF, 2);
    fire(4'b1000, 8'h00, 0, 1, e, k); check("pin_add_wrap", e.e0, 1); settle("add_wrap");
    load2(3, 5);
    fire(4'b1000, 8'h01, 0, 1, e, k); check("pin_sub_neg", e.e0, 32'hFFFF_FFFE); settle("sub_neg");
    load2(32'h11, 32'h22);
    fire(4'b1000, 8'h07, 0, 1, e, k); settle("swap");
    check("pin_swap", m_mem[1], 32'h11);
    load2(5, 32'h11AB_CDEF);
    fire(4'b0100, 8'h12, 0, 1, e, k); check("pin_append", e.e0, 32'hABCD_EF12); settle("append");
    fire(4'b1000, 8'h06, 0, 1, e, k); settle("dup");
    fire(4'b1000, 8'h05, 0, 1, e, k); settle("pop");
    m_cnt = 0;
    fire(4'b0100, 8'h01, 0, 1, e, k); expect_reject("append_empty");
    fire(4'b1000, 8'h05, 0, 1, e, k); expect_reject("pop_empty");

    // Held button, simultaneous presses, ready held low
    m_cnt = 0;
    fire(4'b0010, 8'h5A, 0, 1000, e, k); settle("held");
    check("pin_held_cnt", m_cnt, 1);
    fire(4'b1010, 8'h44, 0, 1, e, k); settle("simul");
    check("pin_simul_top", m_mem[1], 32'h44);
    fire(4'b0010, 8'h66, 5, 1, e, k); settle("ready_low");

    // Back-to-back: next press accepted at t+4
    m_cnt = 0;
    t = cyc;
    fire(4'b0010, 8'h01, 0, 1, e, k);
    repeat (3) begin @(posedge clk); #1; end
    check("pin_t4", cyc, t + 4);
    fire(4'b0010, 8'h02, 0, 1, e, k); settle("b2b");
    check("pin_b2b_cnt", m_cnt, 2);

    // Press while busy is dropped
    load2(100, 7);
    fire(4'b1000, 8'h03, 0, 1, e, k);
    repeat (5) begin @(posedge clk); #1; end
    btn = 4'b0010;
    @(posedge clk); #1;
    btn = 4'b0000;
    settle("drop_busy");
    check("pin_drop_cnt", m_cnt, 1);

    // Reset in the middle of a divide
    load2(100, 7);
    fire(4'b1000, 8'h03, 0, 1, e, k);
    repeat (5) begin @(posedge clk); #1; end
    exp_q.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    m_err = 1'b0;
    @(negedge clk);
    check_zero("rst_div");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (W + 10) @(negedge clk);
    check("rst_div_idle", {31'b0, busy}, 0);
    check("rst_div_cnt", m_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Command sequencer for the RPN stack calculator. Sits between the synchronised buttons/switches and the stack memory block.
- Turns button presses into single stack transactions: push, append, pop, dup, swap, and the add/sub/mul/div/mod operations.
- Checks operand counts, capacity and divide-by-zero before touching the stack, and runs a multi-cycle divider.
- Drives the stack en/ready handshake and the error LED flag.

Parameters:
- DEPTH, 512, stack capacity in elements; a push is refused when elems_cnt == DEPTH.
- W, 32, element width in bits.

Ports:
- clk  in  1  system clock (mclk)
- rst_n  in  1  reset, synchronous, active-low
- btn  in  4  buttons, already synchronised; btn[0] is display-only and ignored here
- sw  in  8  operand / opcode switches, already synchronised
- st_elems_cnt  in  10  current stack element count
- st_top0  in  W  top of stack
- st_top1  in  W  element below top
- st_ready  in  1  stack idle and able to accept en
- st_en  out  1  one-cycle transaction strobe
- st_write_elems_cnt  out  2  elements to write from top (0..2)
- st_write_elem0  out  W  new top value
- st_write_elem1  out  W  new second value
- st_top_mov  out  2  0 = no move, 1 = up (push), 2 = down (pop)
- err_flag  out  1  last command rejected
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - st_en = 0, st_write_elems_cnt = 0, st_write_elem0/1 = 0, st_top_mov = 0, err_flag = 0, busy = 0, state = IDLE.
  - btn_prev is loaded with 4'b1111, so a button held through reset does not fire.
  - Reset during DIV, ISSUE or WAIT aborts the command; no st_en is issued.
- Press detection:
  - press = btn & ~btn_prev; btn_prev is registered every cycle.
  - Presses are acted on only in IDLE. Presses during busy are dropped, not queued.
  - Simultaneous presses are resolved by priority btn[1] > btn[2] > btn[3].
- Commands (cnt = st_elems_cnt):
  - btn[1] PUSH: needs cnt < DEPTH. Issues mov = UP, wcnt = 1, elem0 = {24'b0, sw}.
  - btn[2] APPEND: needs cnt >= 1. Issues mov = NO, wcnt = 1, elem0 = {top0[W-9:0], sw}.
  - btn[3] OP, opcode = sw[2:0]:
    - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD: need cnt >= 2. Issue mov = DN, wcnt = 1, elem0 = result.
    - 5 POP: needs cnt >= 1. Issues mov = DN, wcnt = 0.
    - 6 DUP: needs 1 <= cnt < DEPTH. Issues mov = UP, wcnt = 1, elem0 = top0.
    - 7 SWAP: needs cnt >= 2. Issues mov = NO, wcnt = 2, elem0 = top1, elem1 = top0.
- Arithmetic (a = top1, b = top0):
  - ADD: a + b. SUB: a - b. MUL: low W bits of a*b. All modulo 2^W, no overflow error.
  - DIV and MOD are unsigned a/b and a%b.
  - b == 0 on DIV or MOD sets err_flag and leaves the stack untouched.
- State machine:
  - IDLE:
    - Valid non-divide press: register the outputs and go to ISSUE.
    - Valid DIV or MOD: latch a and b, go to DIV.
    - Invalid press: err_flag <= 1, stay in IDLE.
    - Every accepted command clears err_flag at acceptance.
  - DIV: restoring divider, one quotient bit per cycle, exactly W cycles. Then load quotient or remainder into elem0 and go to ISSUE.
  - ISSUE:
    - If st_ready = 1: st_en = 1 for this one cycle, go to WAIT.
    - Otherwise hold the outputs and stay in ISSUE.
  - WAIT:
    - Ignore st_ready in the first WAIT cycle, because the stack may drop ready one cycle after en.
    - From the second WAIT cycle onward, go to IDLE when st_ready = 1.
  - st_en is never high for two consecutive cycles.
  - Outputs other than st_en hold their values until the next command is accepted.
- Latency:
  - Press detected in cycle t → st_en in cycle t+1 (non-divide, st_ready high).
  - DIV/MOD → st_en in cycle t+1+W.
  - Earliest next accepted press is cycle t+4 (non-divide).

Test Plan:
- Reset, PUSH sw=0x05, PUSH sw=0x03, OP sub (sw[2:0]=1) → transactions: UP/0x05, UP/0x03, DN/wcnt1/elem0=0x02; err_flag stays 0; st_en lasts exactly 1 cycle each.
- Stack model holds 100, 7; OP div → busy for W+1 cycles, then st_en with elem0=14. OP mod on the same operands → elem0=2.
- cnt=1, OP add → no st_en, err_flag=1. Following PUSH → accepted, err_flag=0.
- top1=9, top0=0, OP div → no st_en after DIV is rejected at IDLE, err_flag=1, busy never asserted.
- cnt=DEPTH, PUSH and DUP → both rejected, err_flag=1. cnt=DEPTH-1, PUSH → accepted.
- Button held 1000 cycles → exactly one st_en. btn[1] and btn[3] rising in the same cycle → only PUSH issued. st_ready held low 5 cycles in ISSUE → st_en waits, then fires once. rst_n low mid-DIV → no st_en, all outputs 0.
